// File: rtl/cache_axi_pkg.sv
// Shared encodings and AXI constants for the instruction-cache miss bridge.
package cache_axi_pkg;

    typedef enum logic [3:0] {
        ST_IDLE = 4'b0001,
        ST_AR   = 4'b0010,
        ST_R    = 4'b0100,
        ST_RESP = 4'b1000
    } state_e;

    localparam logic [2:0] SIZE_4B      = 3'b010;
    localparam logic [1:0] BURST_INCR   = 2'b01;
    localparam int         LINE_BEATS   = 8;
    localparam int         LINE_W       = 256;
    localparam logic       RD_TYPE_LINE = 1'b1;
    localparam logic       RD_TYPE_WORD = 1'b0;

    // Line reads start on the 32-byte boundary; word reads use the exact address.
    function automatic logic [31:0] burst_addr(input logic rd_type, input logic [31:0] addr);
        return (rd_type == RD_TYPE_LINE) ? {addr[31:5], 5'b0} : addr;
    endfunction

endpackage

// File: rtl/icache_axi_rd_bridge.sv
// Instruction-cache miss responder: one AXI4 read burst per request, beats
// gathered into a 256-bit line and returned as a single-cycle pulse.
module icache_axi_rd_bridge
    import cache_axi_pkg::*;
#(
    parameter int                AXI_ID_W = 4,
    parameter logic [AXI_ID_W-1:0] ARID_VAL = '0
) (
    input  logic                clk,
    input  logic                reset,
    // rd_req is taken only while rd_rdy is high; the requester holds it otherwise.
    input  logic                rd_req,
    input  logic                rd_type,
    input  logic [31:0]         rd_addr,
    output logic                rd_rdy,
    output logic                ret_valid,
    output logic [LINE_W-1:0]   ret_data,
    output logic [AXI_ID_W-1:0] arid,
    output logic [31:0]         araddr,
    output logic [7:0]          arlen,
    output logic [2:0]          arsize,
    output logic [1:0]          arburst,
    output logic                arvalid,
    input  logic                arready,
    input  logic [AXI_ID_W-1:0] rid,
    input  logic [31:0]         rdata,
    input  logic [1:0]          rresp,
    input  logic                rlast,
    input  logic                rvalid,
    output logic                rready,
    output logic [3:0]          dbg_state
);

    state_e              state_q, state_d;
    logic                type_q, type_d;
    logic [31:0]         addr_q, addr_d;
    logic [2:0]          beat_q, beat_d;
    logic [LINE_W-1:0]   line_q, line_d;
    logic                arvalid_q, arvalid_d;
    logic                rready_q, rready_d;
    logic                ret_valid_q, ret_valid_d;
    logic                unused_inputs;

    assign unused_inputs = ^{rid, rresp};

    always_comb begin
        state_d     = state_q;
        type_d      = type_q;
        addr_d      = addr_q;
        beat_d      = beat_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;
        ret_valid_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rd_req) begin
                    type_d    = rd_type;
                    addr_d    = rd_addr;
                    beat_d    = 3'd0;
                    arvalid_d = 1'b1;
                    state_d   = ST_AR;
                end
            end
            ST_AR: begin
                if (arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = ST_R;
                end
            end
            ST_R: begin
                if (rvalid) begin
                    beat_d = beat_q + 3'd1;
                    // Only rlast ends the burst; the beat count is never checked.
                    if (rlast) begin
                        rready_d    = 1'b0;
                        ret_valid_d = 1'b1;
                        state_d     = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                arvalid_d = 1'b0;
                rready_d  = 1'b0;
            end
        endcase
    end

    always_comb begin
        line_d = line_q;
        if (state_q == ST_IDLE && rd_req) begin
            line_d = '0;
        end else if (state_q == ST_R && rvalid) begin
            line_d[{beat_q, 5'b0} +: 32] = rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            type_q      <= RD_TYPE_WORD;
            addr_q      <= '0;
            beat_q      <= '0;
            line_q      <= '0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
            ret_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            type_q      <= type_d;
            addr_q      <= addr_d;
            beat_q      <= beat_d;
            line_q      <= line_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
            ret_valid_q <= ret_valid_d;
        end
    end

    assign rd_rdy    = (state_q == ST_IDLE);
    assign ret_valid = ret_valid_q;
    assign ret_data  = line_q;
    assign arid      = ARID_VAL;
    assign araddr    = burst_addr(type_q, addr_q);
    assign arlen     = (type_q == RD_TYPE_LINE) ? 8'(LINE_BEATS - 1) : 8'd0;
    assign arsize    = SIZE_4B;
    assign arburst   = BURST_INCR;
    assign arvalid   = arvalid_q;
    assign rready    = rready_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_icache_axi_rd_bridge.sv
// Directed bench for icache_axi_rd_bridge: transaction model checked every cycle
// plus literal expectations for each scenario.
module tb_icache_axi_rd_bridge;

  logic         clk = 1'b0;
  logic         reset;
  logic         rd_req;
  logic         rd_type;
  logic [31:0]  rd_addr;
  logic         rd_rdy;
  logic         ret_valid;
  logic [255:0] ret_data;
  logic [3:0]   arid;
  logic [31:0]  araddr;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic [1:0]   arburst;
  logic         arvalid;
  logic         arready;
  logic [3:0]   rid;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rlast;
  logic         rvalid;
  logic         rready;
  logic [3:0]   dbg_state;

  int checks = 0;
  int failures = 0;
  int ret_cnt = 0;
  int ar_hs = 0;
  bit chk_en = 0;
  logic [255:0] exp_q[$];

  // transaction model
  bit           m_busy, m_ar, m_r, m_ret, m_type;
  logic [31:0]  m_addr;
  logic [2:0]   m_beat;
  logic [255:0] m_line;

  icache_axi_rd_bridge #(.AXI_ID_W(4), .ARID_VAL(4'd0)) dut (
    .clk(clk), .reset(reset), .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr),
    .rd_rdy(rd_rdy), .ret_valid(ret_valid), .ret_data(ret_data), .arid(arid),
    .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready), .rid(rid), .rdata(rdata), .rresp(rresp),
    .rlast(rlast), .rvalid(rvalid), .rready(rready), .dbg_state(dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired got=running exp=finished");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // model advances on the same edges the DUT samples its inputs
  always @(posedge clk) begin
    if (reset) begin
      m_busy <= 0; m_ar <= 0; m_r <= 0; m_ret <= 0; m_beat <= '0; m_line <= '0;
      m_type <= 0; m_addr <= '0;
    end else if (m_ret) begin
      m_ret <= 0; m_busy <= 0;
    end else if (!m_busy) begin
      if (rd_req) begin
        m_busy <= 1; m_type <= rd_type; m_addr <= rd_addr;
        m_line <= '0; m_beat <= '0; m_ar <= 1;
      end
    end else if (m_ar) begin
      if (arready) begin
        m_ar <= 0; m_r <= 1; ar_hs <= ar_hs + 1;
      end
    end else if (m_r && rvalid) begin
      m_line[m_beat*32 +: 32] <= rdata;
      m_beat <= m_beat + 3'd1;
      if (rlast) begin
        m_r <= 0; m_ret <= 1;
      end
    end
  end

  // compare process
  always @(negedge clk) begin
    if (chk_en) begin
      chk("rd_rdy", 256'(rd_rdy), 256'(!m_busy));
      chk("arvalid", 256'(arvalid), 256'(m_ar));
      chk("rready", 256'(rready), 256'(m_r));
      chk("ret_valid", 256'(ret_valid), 256'(m_ret));
      chk("ret_data_track", ret_data, m_line);
      if (m_ar) begin
        chk("araddr", 256'(araddr), 256'(m_type ? (m_addr & ~32'h1F) : m_addr));
        chk("arlen", 256'(arlen), 256'(m_type ? 8'd7 : 8'd0));
        chk("arsize", 256'(arsize), 256'(3'b010));
        chk("arburst", 256'(arburst), 256'(2'b01));
        chk("arid", 256'(arid), 256'(4'd0));
      end
      if (ret_valid) ret_cnt++;
      if (m_ret) begin
        if (exp_q.size() == 0) chk("ret_unexpected", 256'(1), 256'(0));
        else chk("ret_line", ret_data, exp_q.pop_front());
      end
    end
  end

  // driver tasks: each starts and ends just after a negedge
  task automatic do_req(input logic t, input logic [31:0] a);
    int n = 0;
    rd_req = 1; rd_type = t; rd_addr = a;
    while (!rd_rdy && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("req_timeout", 256'(0), 256'(1));
    @(negedge clk);
    rd_req = 0;
  endtask

  task automatic do_ar(input int stall);
    int n = 0;
    arready = 0;
    while (!arvalid && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("ar_timeout", 256'(0), 256'(1));
    repeat (stall) @(negedge clk);
    arready = 1;
    @(negedge clk);
    arready = 0;
  endtask

  task automatic do_beats(input int nb, input logic [255:0] words, input int gap, input bit last);
    logic [255:0] exp_line = '0;
    for (int k = 0; k < nb; k++) begin
      int n = 0;
      rvalid = 1;
      rdata = words[k*32 +: 32];
      rlast = last && (k == nb - 1);
      exp_line[k*32 +: 32] = words[k*32 +: 32];
      if (rlast) exp_q.push_back(exp_line);
      while (!rready && n < 50) begin @(negedge clk); n++; end
      if (n >= 50) chk("r_timeout", 256'(0), 256'(1));
      @(negedge clk);
      rvalid = 0; rlast = 0;
      repeat (gap) @(negedge clk);
    end
  endtask

  initial begin
    logic [255:0] w_line, w_bp, w_busy, w_rst, w_new;
    reset = 1; rd_req = 0; rd_type = 0; rd_addr = '0; arready = 0;
    rid = '0; rdata = '0; rresp = '0; rlast = 0; rvalid = 0;
    repeat (2) @(negedge clk);
    chk_en = 1;
    @(negedge clk);
    reset = 0;
    chk("reset_rd_rdy", 256'(rd_rdy), 256'(1));
    chk("reset_arvalid", 256'(arvalid), 256'(0));
    chk("reset_rready", 256'(rready), 256'(0));
    chk("reset_ret_valid", 256'(ret_valid), 256'(0));
    chk("reset_ret_data", ret_data, 256'(0));

    // line read
    w_line = {32'h88888888, 32'h77777777, 32'h66666666, 32'h55555555,
              32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    do_req(1, 32'h1FC0_0024);
    chk("line_araddr", 256'(araddr), 256'(32'h1FC0_0020));
    chk("line_arlen", 256'(arlen), 256'(8'd7));
    do_ar(0);
    do_beats(8, w_line, 0, 1);
    chk("line_ret_valid", 256'(ret_valid), 256'(1));
    chk("line_word0", 256'(ret_data[31:0]), 256'(32'h11111111));
    chk("line_word7", 256'(ret_data[255:224]), 256'(32'h88888888));
    @(negedge clk);
    chk("line_hold", 256'(ret_data[159:128]), 256'(32'h55555555));

    // uncached read
    do_req(0, 32'hBFAF_8004);
    chk("word_araddr", 256'(araddr), 256'(32'hBFAF_8004));
    chk("word_arlen", 256'(arlen), 256'(8'd0));
    do_ar(0);
    do_beats(1, {224'b0, 32'hDEADBEEF}, 0, 1);
    chk("word_ret_data", ret_data, {224'b0, 32'hDEADBEEF});
    @(negedge clk);

    // back-pressure on AR and R
    for (int k = 0; k < 8; k++) w_bp[k*32 +: 32] = 32'hA000_0000 + 32'(k * 3);
    do_req(1, 32'h0000_1044);
    do_ar(5);
    do_beats(8, w_bp, 1, 1);
    chk("bp_word5", 256'(ret_data[191:160]), 256'(32'hA000_000F));
    @(negedge clk);
    chk("bp_ret_count", 256'(ret_cnt), 256'(3));

    // request held while busy
    for (int k = 0; k < 8; k++) w_busy[k*32 +: 32] = 32'hB000_0100 + 32'(k);
    do_req(1, 32'h2000_0000);
    do_ar(0);
    rd_req = 1; rd_type = 0; rd_addr = 32'h3000_0008;
    chk("busy_rd_rdy", 256'(rd_rdy), 256'(0));
    do_beats(8, w_busy, 0, 1);
    do_req(0, 32'h3000_0008);
    chk("busy_ar_count", 256'(ar_hs), 256'(4));
    chk("busy_araddr", 256'(araddr), 256'(32'h3000_0008));
    do_ar(0);
    do_beats(1, {224'b0, 32'hCAFEF00D}, 0, 1);
    @(negedge clk);

    // reset in the middle of a burst
    for (int k = 0; k < 8; k++) w_rst[k*32 +: 32] = 32'hEEEE_0000 + 32'(k);
    for (int k = 0; k < 8; k++) w_new[k*32 +: 32] = 32'h5A00_0000 + 32'(k << 4);
    do_req(1, 32'h0000_4000);
    do_ar(0);
    do_beats(3, w_rst, 0, 0);
    reset = 1;
    @(negedge clk);
    reset = 0;
    chk("rst_arvalid", 256'(arvalid), 256'(0));
    chk("rst_rready", 256'(rready), 256'(0));
    chk("rst_rd_rdy", 256'(rd_rdy), 256'(1));
    chk("rst_ret_valid", 256'(ret_valid), 256'(0));
    do_req(1, 32'h0000_4000);
    do_ar(0);
    do_beats(8, w_new, 0, 1);
    chk("rst_word2", 256'(ret_data[95:64]), 256'(32'h5A00_0020));
    repeat (3) @(negedge clk);
    chk("final_ret_count", 256'(ret_cnt), 256'(6));
    chk("final_exp_empty", 256'(exp_q.size()), 256'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/icache_axi_rd_bridge.md
Name: icache_axi_rd_bridge

Overview:
- Responder end of the instruction-cache miss interface. Accepts one cache-line or uncached read request at a time (rd_req/rd_rdy), issues the matching AXI4 read burst, and collects 32-bit R beats into a 256-bit line.
- Returns the collected line to the cache as a single-cycle ret_valid/ret_data pulse.
- Sits between the instruction cache and the AXI crossbar/arbiter. Read-only, one outstanding transaction.

Parameters:
- AXI_ID_W, 4, width of arid/rid.
- ARID_VAL, 0, constant ID driven on arid.

Ports:
- clk  in  1  clock, all logic posedge.
- reset  in  1  synchronous, active-high reset.
- rd_req  in  1  cache read request.
- rd_type  in  1  1 = 32-byte cache line, 0 = single uncached word.
- rd_addr  in  32  request byte address.
- rd_rdy  out  1  bridge can accept a request this cycle.
- ret_valid  out  1  one-cycle pulse, read data complete.
- ret_data  out  256  line data; word k = beat k; uncached word in [31:0].
- arid  out  AXI_ID_W  = ARID_VAL.
- araddr  out  32  burst start address.
- arlen  out  8  beats minus 1.
- arsize  out  3  fixed 3'b010 (4 bytes).
- arburst  out  2  fixed 2'b01 (INCR).
- arvalid  out  1  AR valid.
- arready  in  1  AR ready.
- rid  in  AXI_ID_W  ignored.
- rdata  in  32  R data.
- rresp  in  2  ignored (no error reporting).
- rlast  in  1  last beat.
- rvalid  in  1  R valid.
- rready  out  1  R ready.

Behaviour:
- Reset values: state IDLE; rd_rdy=1 (combinational from IDLE); ret_valid=0; arvalid=0; rready=0; ret_data=0; beat counter 0.
- States (one-hot): IDLE, AR, R, RESP.
- IDLE:
  - rd_rdy=1.
  - On rd_req&&rd_rdy: latch rd_type and rd_addr, clear line buffer to 0, clear beat counter, go to AR.
- AR:
  - arvalid=1.
  - araddr = rd_type ? {addr[31:5],5'b0} : addr.
  - arlen = rd_type ? 8'd7 : 8'd0.
  - arvalid and araddr/arlen stay stable until arready. On arvalid&&arready go to R.
- R:
  - rready=1.
  - Each rvalid&&rready beat writes rdata into buffer word [beat counter], then increments the counter (3-bit, wraps).
  - The beat with rlast=1 ends the burst: go to RESP. Termination depends on rlast only; beat count is not checked.
- RESP:
  - ret_valid=1 for exactly this cycle, ret_data = buffer (registered, stable this cycle).
  - Next cycle go to IDLE.
- Latency, with zero-wait slave (request accepted in cycle 0):
  - arvalid in cycle 1.
  - First R beat no earlier than cycle 2.
  - ret_valid is 1 cycle after the rlast handshake.
  - rd_rdy is 1 again the cycle after ret_valid.
- rd_req outside IDLE: ignored (rd_rdy=0). The requester holds it.
- Back-pressure: rvalid gaps are allowed, and the counter advances only on handshake. arready may stay low indefinitely.
- Uncached read: only word 0 is written, words 1..7 read 0.
- Reset mid-operation returns to IDLE immediately and drops arvalid/rready. The partial line is discarded and no ret_valid is produced. Slaves share the same reset.
- ret_data stays at its last value after the RESP cycle until the next request clears the buffer.

Decomposition:
- Shared package (cache_axi_pkg): state encodings, AXI constants (SIZE_4B=3'b010, BURST_INCR=2'b01), LINE_BEATS=8, RD_TYPE_LINE=1 / RD_TYPE_WORD=0.
- No sub-module needed. The line buffer with word-indexed write is a single always block inside this module.

Test Plan:
- Line read: rd_req, type 1, addr 0x1FC0_0024 -> araddr 0x1FC0_0020, arlen 7. R beats 0x11111111..0x88888888 with rlast on beat 8 -> one ret_valid cycle with ret_data[31:0]=0x11111111 and [255:224]=0x88888888.
- Uncached read: type 0, addr 0xBFAF_8004 -> araddr 0xBFAF_8004, arlen 0. One beat 0xDEADBEEF with rlast -> ret_data = {224'b0, 32'hDEADBEEF}, ret_valid 1 cycle.
- Back-pressure: arready held low 5 cycles, rvalid toggling every other cycle -> arvalid/araddr stable throughout, data placed at correct words, exactly one ret_valid.
- Request while busy: rd_req held high during R -> rd_rdy=0 and no second AR. Second AR issues only after returning to IDLE.
- Reset mid-burst: assert reset after beat 3 -> next cycle arvalid=0, rready=0, rd_rdy=1, no ret_valid. A following line read returns correct data with stale words overwritten.
